mmm_io_loader: RTL
==================

# mmm_io_loader

Host-side transmitter for the matrix-multiply I/O black box load protocol. It accepts a stream of packed A/B operand words from the host, drives the black box's input handshake, write address and data ports, and signals end of load with `input_finish`. It then waits for the black box result handshake (`output_valid`/`output_ready`) and reports job completion to the host.

## Interface
- `SRAM_DATA_WIDTH`, 32, width of each of the four operand lanes (a0, a1, b0, b1).
- `ADDR_WIDTH`, 10, width of the black box write address.
- `MAX_WORDS`, 256, black box memory depth, in words per job.
- `clk`  in  1  single clock. All state changes on the rising edge.
- `srstn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  host job request. Sampled only in IDLE.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse when the result handshake completes.
- `load_trunc`  out  1  sticky. Set when a job reaches `MAX_WORDS` without `s_last`. Cleared on an accepted `start`.
- `word_count`  out  9  number of words accepted in the current or last job.
- `s_valid`  in  1  host word valid.
- `s_ready`  out  1  loader accepts the host word.
- `s_data`  in  4*SRAM_DATA_WIDTH  packed word {a0,a1,b0,b1}, with a0 in the MSBs.
- `s_last`  in  1  marks the final word of the job.
- `bb_input_valid`  out  1  load request to the black box.
- `bb_input_ready`  in  1  black box idle / ready.
- `bb_input_finish`  out  1  end-of-load indication.
- `bb_sram_raddr`  out  ADDR_WIDTH  black box write address.
- `bb_sram_rdata_a0`, `bb_sram_rdata_a1`, `bb_sram_rdata_b0`, `bb_sram_rdata_b1`  out  SRAM_DATA_WIDTH each  operand lanes.
- `bb_output_valid`  in  1  black box result available.
- `bb_output_ready`  out  1  result acknowledge.

## Operation
- Reset values: every output is 0. This includes `bb_sram_raddr`, all data lanes, and `word_count`. The state is IDLE and the internal next-address counter is 0.
- The black box writes its memory at `bb_sram_raddr` on every clock edge, unconditionally.
  - Consequently, the address and data outputs are registered and change only when a host word is accepted.
  - At all other times they hold their value, so that a repeated write is idempotent.
- States:
  - IDLE
    - `start`=1 moves to REQ.
    - On that transition: next-address=0, `word_count`=0, `load_trunc`=0.
  - REQ
    - `bb_input_valid`=1.
    - Moves to STREAM on the edge where `bb_input_ready`=1.
  - STREAM
    - `s_ready`=1.
    - On `s_valid`&&`s_ready`:
      - `bb_sram_raddr` takes next-address.
      - The lanes take the slices of `s_data`.
      - next-address and `word_count` increment.
    - Moves to FINISH if the accepted word has `s_last`=1, or if it is word number `MAX_WORDS`. In the second case, without `s_last`, `load_trunc` is set.
  - FINISH
    - `bb_input_finish`=1 for exactly one cycle.
    - `s_ready`=0.
    - Moves to WAIT.
  - WAIT
    - Moves to ACK when `bb_output_valid`=1.
  - ACK
    - `bb_output_ready`=1.
    - Moves to IDLE on the edge where `bb_output_valid`=1.
    - `done` is pulsed in the following cycle (registered).
- `bb_input_valid`, `bb_input_finish`, `bb_output_ready`, `s_ready` and `busy` are state decodes with no glitch paths from the inputs.
- The host may stall (`s_valid`=0) for any number of cycles in STREAM. The outputs hold during the stall.
- `start` outside IDLE is ignored.
- An asserted `srstn` at any point, including mid-load, forces the state to IDLE and all outputs to 0 immediately.

## Timing
- Start to request: `start` sampled at edge 0, then `bb_input_valid`=1 in cycle 1.
- Request to stream: if `bb_input_ready`=1 in cycle 1, then `s_ready`=1 from cycle 2.
- Load throughput: one word per cycle.
- Word to memory write: a word accepted at edge k is presented in cycle k+1 and written by the black box at edge k+1.
- Finish alignment: after the last word is accepted at edge k, `bb_input_finish`=1 in cycle k+1. It coincides with the black box's write of that last word.
- Result to completion: `bb_output_valid` seen at edge m while in WAIT, then `bb_output_ready`=1 in cycle m+1, then `done`=1 in cycle m+2 when valid is still high.
- Minimum job with 1 word and immediate ready/valid: `start` to `done` is 7 cycles.

## Test plan
- **Reset:** assert `srstn`=0 mid-STREAM after 5 words. Required: all outputs 0 asynchronously, `busy`=0, and the next job restarts at address 0.
- **Basic load:**
  - Stimulus: `start`, then 4 words with `s_data`=0x{00000001,00000002,00000003,00000004}+i, with `s_last` on i=3.
  - Required addresses: `bb_sram_raddr` sequence 0,1,2,3.
  - Required data: `bb_sram_rdata_a0`=1+i and `bb_sram_rdata_b1`=4+i.
  - Required finish: `bb_input_finish` high for exactly one cycle, in the cycle after the address-3 word is accepted.
  - Required count: `word_count`=4.
- **Host stalls:** `s_valid` toggles 1,0,0,1,0,1. Required: address and data hold during the stalled cycles, with no extra increments.
- **Delayed handshakes:** `bb_input_ready` low for 3 cycles in REQ, and `bb_output_valid` arrives 20 cycles after finish. Required: `bb_input_valid` held throughout, `bb_output_ready` only after valid, and a single `done` pulse.
- **Truncation:** 300 words without `s_last`. Required: exactly 256 accepted, last address 255, `s_ready` drops, `load_trunc`=1 until the next `start`.
- **Ignored start:** pulse `start` during WAIT. Required: no state change, and `load_trunc` and `word_count` unchanged.

Source files
------------

// File: rtl/mmm_io_loader_if.sv
// Black box load-side bus: input handshake, write address/data lanes and result handshake.
// The loader drives the master modport; the black box (or its model) uses the slave modport.
interface mmm_io_loader_if #(
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10
);
  logic                       bb_input_valid;
  logic                       bb_input_ready;
  logic                       bb_input_finish;
  logic [ADDR_WIDTH-1:0]      bb_sram_raddr;
  logic [SRAM_DATA_WIDTH-1:0] bb_sram_rdata_a0;
  logic [SRAM_DATA_WIDTH-1:0] bb_sram_rdata_a1;
  logic [SRAM_DATA_WIDTH-1:0] bb_sram_rdata_b0;
  logic [SRAM_DATA_WIDTH-1:0] bb_sram_rdata_b1;
  logic                       bb_output_valid;
  logic                       bb_output_ready;

  modport master (
    output bb_input_valid,
    input  bb_input_ready,
    output bb_input_finish,
    output bb_sram_raddr,
    output bb_sram_rdata_a0,
    output bb_sram_rdata_a1,
    output bb_sram_rdata_b0,
    output bb_sram_rdata_b1,
    input  bb_output_valid,
    output bb_output_ready
  );

  modport slave (
    input  bb_input_valid,
    output bb_input_ready,
    input  bb_input_finish,
    input  bb_sram_raddr,
    input  bb_sram_rdata_a0,
    input  bb_sram_rdata_a1,
    input  bb_sram_rdata_b0,
    input  bb_sram_rdata_b1,
    output bb_output_valid,
    input  bb_output_ready
  );
endinterface

// File: rtl/mmm_io_loader.sv
// Host-side loader for the matrix-multiply black box: streams packed A/B words into the
// black box memory, signals end of load, then waits for the result handshake.
module mmm_io_loader #(
  parameter int SRAM_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int MAX_WORDS       = 256
) (
  input  logic                         clk,
  input  logic                         srstn,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic                         load_trunc,
  output logic [8:0]                   word_count,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [4*SRAM_DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  mmm_io_loader_if.master              bb
);

  localparam int         DW       = SRAM_DATA_WIDTH;
  localparam logic [8:0] LAST_IDX = 9'(MAX_WORDS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ    = 3'd1,
    ST_STREAM = 3'd2,
    ST_FINISH = 3'd3,
    ST_WAIT   = 3'd4,
    ST_ACK    = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  logic [DW-1:0]         a0_q, a0_d;
  logic [DW-1:0]         a1_q, a1_d;
  logic [DW-1:0]         b0_q, b0_d;
  logic [DW-1:0]         b1_q, b1_d;
  logic [8:0]            count_q, count_d;
  logic                  trunc_q, trunc_d;
  logic                  done_q, done_d;

  logic start_acc_s;
  logic accept_s;
  logic last_slot_s;
  logic end_load_s;
  logic ack_hs_s;

  // Handshake qualifiers derived from the registered state and the inputs.
  always_comb begin
    start_acc_s = (state_q == ST_IDLE) && start;
    accept_s    = (state_q == ST_STREAM) && s_valid;
    last_slot_s = (count_q == LAST_IDX);
    end_load_s  = accept_s && (s_last || last_slot_s);
    ack_hs_s    = (state_q == ST_ACK) && bb.bb_output_valid;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_REQ;
        else       state_d = ST_IDLE;
      end
      ST_REQ: begin
        if (bb.bb_input_ready) state_d = ST_STREAM;
        else                   state_d = ST_REQ;
      end
      ST_STREAM: begin
        if (end_load_s) state_d = ST_FINISH;
        else            state_d = ST_STREAM;
      end
      ST_FINISH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bb.bb_output_valid) state_d = ST_ACK;
        else                    state_d = ST_WAIT;
      end
      ST_ACK: begin
        if (bb.bb_output_valid) state_d = ST_IDLE;
        else                    state_d = ST_ACK;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The black box writes every edge, so address and lanes move only on an accepted word.
  always_comb begin
    next_addr_d = next_addr_q;
    raddr_d     = raddr_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    count_d     = count_q;
    trunc_d     = trunc_q;
    if (start_acc_s) begin
      next_addr_d = {ADDR_WIDTH{1'b0}};
      count_d     = 9'd0;
      trunc_d     = 1'b0;
    end else if (accept_s) begin
      raddr_d     = next_addr_q;
      a0_d        = s_data[4*DW-1 -: DW];
      a1_d        = s_data[3*DW-1 -: DW];
      b0_d        = s_data[2*DW-1 -: DW];
      b1_d        = s_data[DW-1 -: DW];
      next_addr_d = next_addr_q + ADDR_WIDTH'(1);
      count_d     = count_q + 9'd1;
      if (last_slot_s && !s_last) trunc_d = 1'b1;
      else                        trunc_d = trunc_q;
    end else begin
      count_d = count_q;
    end
    if (ack_hs_s) done_d = 1'b1;
    else          done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      next_addr_q <= {ADDR_WIDTH{1'b0}};
      raddr_q     <= {ADDR_WIDTH{1'b0}};
      a0_q        <= {DW{1'b0}};
      a1_q        <= {DW{1'b0}};
      b0_q        <= {DW{1'b0}};
      b1_q        <= {DW{1'b0}};
      count_q     <= 9'd0;
      trunc_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      next_addr_q <= next_addr_d;
      raddr_q     <= raddr_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      count_q     <= count_d;
      trunc_q     <= trunc_d;
      done_q      <= done_d;
    end
  end

  // Handshake strobes decode the state register only, so inputs cannot glitch them.
  always_comb begin
    busy               = 1'b1;
    s_ready            = 1'b0;
    bb.bb_input_valid  = 1'b0;
    bb.bb_input_finish = 1'b0;
    bb.bb_output_ready = 1'b0;
    case (state_q)
      ST_IDLE:   busy               = 1'b0;
      ST_REQ:    bb.bb_input_valid  = 1'b1;
      ST_STREAM: s_ready            = 1'b1;
      ST_FINISH: bb.bb_input_finish = 1'b1;
      ST_WAIT:   busy               = 1'b1;
      ST_ACK:    bb.bb_output_ready = 1'b1;
      default:   busy               = 1'b0;
    endcase
  end

  assign bb.bb_sram_raddr    = raddr_q;
  assign bb.bb_sram_rdata_a0 = a0_q;
  assign bb.bb_sram_rdata_a1 = a1_q;
  assign bb.bb_sram_rdata_b0 = b0_q;
  assign bb.bb_sram_rdata_b1 = b1_q;
  assign word_count          = count_q;
  assign load_trunc          = trunc_q;
  assign done                = done_q;

endmodule
